// File: rtl/inst_encoder.sv
// ----------------------------------------------------------------------------
// inst_encoder
// Streaming RV32I instruction encoder and program loader. Decoded field
// bundles arrive over a valid/ready handshake, are validated and packed into
// 32-bit RV32I words, and are written one per cycle into instruction memory
// starting at a base word address latched when a session starts.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start / finish      open a session (IDLE/DONE) / close it (RUN)
//   base_addr           first write address, sampled on an honoured start
//   in_valid/in_ready   bundle handshake
//   in_class .. in_imm  decoded fields (class, registers, funct3, inst[30], imm)
//   mem_we/addr/wdata   instruction memory write port (one cycle after accept)
//   err/err_code        one-cycle reject pulse and reason
//   err_count           saturating reject count for the session
//   count               words written this session
//   done / full         session ended / DEPTH words written
// ----------------------------------------------------------------------------
module inst_encoder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_alt,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err,
    output logic [2:0]        err_code,
    output logic [7:0]        err_count,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              full
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Pack a validated bundle into its RV32I format.
    function automatic logic [31:0] encode(input logic [3:0] cls, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [2:0] f3, input logic alt,
                                           input logic [31:0] imm);
        logic [31:0] w;
        w = 32'd0;
        case (cls)
            4'd0: w = {1'b0, alt, 5'b00000, rs2, rs1, f3, rd, OP_R};
            4'd1: begin
                // Shifts carry shamt in the rs2 slot; only SRAI may set inst[30].
                if ((f3 == 3'd1) || (f3 == 3'd5)) begin
                    w = {1'b0, alt & (f3 == 3'd5), 5'b00000, imm[4:0], rs1, f3, rd, OP_I};
                end else begin
                    w = {imm[11:0], rs1, f3, rd, OP_I};
                end
            end
            4'd2:    w = {imm[11:0], rs1, f3, rd, OP_LOAD};
            4'd3:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
            4'd4:    w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
            4'd5:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            4'd6:    w = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            4'd7:    w = {imm[31:12], rd, OP_LUI};
            4'd8:    w = {imm[31:12], rd, OP_AUIPC};
            4'd9:    w = {imm[11:0], rs1, f3, rd, OP_SYSTEM};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    // Reject reason for a bundle, 0 when it encodes cleanly.
    function automatic logic [2:0] check_bundle(input logic [3:0] cls, input logic [2:0] f3,
                                                input logic [31:0] imm);
        logic       fits12;
        logic       b_range;
        logic       j_range;
        logic [2:0] code;
        fits12  = (imm == {{20{imm[11]}}, imm[11:0]});
        // Sign-extension tests give -4096..4095 / -2^20..2^20-1; the odd top
        // value is outside the legal range and must report a range error.
        b_range = (imm == {{19{imm[12]}}, imm[12:0]}) && (imm != 32'd4095);
        j_range = (imm == {{11{imm[20]}}, imm[20:0]}) && (imm != 32'h000F_FFFF);
        code    = 3'd0;
        case (cls)
            4'd0: code = 3'd0;
            4'd1: begin
                if ((f3 == 3'd1) || (f3 == 3'd5)) begin
                    code = (imm[31:5] != 27'd0) ? 3'd2 : 3'd0;
                end else begin
                    code = fits12 ? 3'd0 : 3'd2;
                end
            end
            4'd2, 4'd3, 4'd6, 4'd9: code = fits12 ? 3'd0 : 3'd2;
            4'd4: begin
                if ((f3 == 3'd2) || (f3 == 3'd3)) begin
                    code = 3'd4;
                end else if (!b_range) begin
                    code = 3'd2;
                end else if (imm[0]) begin
                    code = 3'd3;
                end else begin
                    code = 3'd0;
                end
            end
            4'd5: begin
                if (!j_range) begin
                    code = 3'd2;
                end else if (imm[0]) begin
                    code = 3'd3;
                end else begin
                    code = 3'd0;
                end
            end
            4'd7, 4'd8: code = (imm[11:0] != 12'd0) ? 3'd2 : 3'd0;
            default:    code = 3'd1;
        endcase
        return code;
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   base_r;
    logic [ADDR_W:0]     count_r;
    logic                full_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [31:0]         mem_wdata_r;
    logic                err_r;
    logic [2:0]          err_code_r;
    logic [7:0]          err_count_r;

    logic [ADDR_W:0]     occupancy_s;
    logic                ready_s;
    logic                accept_s;
    logic [2:0]          code_s;
    logic                good_s;
    logic                bad_s;
    logic                start_take_s;
    logic                last_write_s;

    // Words committed or in flight; the pending write still counts toward DEPTH.
    assign occupancy_s  = count_r + {{ADDR_W{1'b0}}, mem_we_r};
    assign ready_s      = (state_r == RUN) && (occupancy_s < DEPTH_C);
    assign accept_s     = in_valid && ready_s;
    assign code_s       = check_bundle(in_class, in_funct3, in_imm);
    assign good_s       = accept_s && (code_s == 3'd0);
    assign bad_s        = accept_s && (code_s != 3'd0);
    assign start_take_s = start && ((state_r == IDLE) || (state_r == DONE));
    assign last_write_s = mem_we_r && (count_r == LAST_C);

    // Session sequencing: finish has priority over start and over the full stop.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                if (finish) begin
                    state_s = good_s ? DRAIN : DONE;
                end else if (last_write_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            // DRAIN is only entered with a write pending, which retires now.
            DRAIN:   state_s = DONE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Write port: a clean accept becomes a one-cycle memory write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 32'd0;
        end else begin
            mem_we_r <= good_s;
            if (good_s) begin
                mem_addr_r  <= base_r + occupancy_s[ADDR_W-1:0];
                mem_wdata_r <= encode(in_class, in_rd, in_rs1, in_rs2, in_funct3, in_alt, in_imm);
            end else begin
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    // Reject reporting: pulse in the write slot plus a saturating counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r       <= 1'b0;
            err_code_r  <= 3'd0;
            err_count_r <= 8'd0;
        end else begin
            err_r      <= bad_s;
            err_code_r <= bad_s ? code_s : 3'd0;
            if (start_take_s) begin
                err_count_r <= 8'd0;
            end else if (bad_s && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'd1;
            end else begin
                err_count_r <= err_count_r;
            end
        end
    end

    // Session bookkeeping: base latch, retired-word count and full flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_r  <= {ADDR_W{1'b0}};
            count_r <= {(ADDR_W+1){1'b0}};
            full_r  <= 1'b0;
        end else if (start_take_s) begin
            base_r  <= base_addr;
            count_r <= {(ADDR_W+1){1'b0}};
            full_r  <= 1'b0;
        end else begin
            base_r  <= base_r;
            count_r <= mem_we_r ? (count_r + {{ADDR_W{1'b0}}, 1'b1}) : count_r;
            full_r  <= full_r | last_write_s;
        end
    end

    assign in_ready  = ready_s;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign err       = err_r;
    assign err_code  = err_code_r;
    assign err_count = err_count_r;
    assign count     = count_r;
    assign done      = (state_r == DONE);
    assign full      = full_r;

endmodule

// File: tb/tb_inst_encoder.sv
// ----------------------------------------------------------------------------
// tb_inst_encoder
// Self-checking bench for inst_encoder. Expected writes/rejects are pushed to
// scoreboard queues as bundles are driven; a negedge monitor collects what the
// DUT produces and each test task compares the two. A second instance built
// with DEPTH=4 covers the full/stop behaviour.
// ----------------------------------------------------------------------------
module tb_inst_encoder;

    localparam int AW = 10;

    typedef struct {
        int          cyc;
        logic [AW-1:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0, finish = 1'b0, in_valid = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [3:0]    in_class = '0;
    logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]    in_funct3 = '0;
    logic          in_alt = 1'b0;
    logic [31:0]   in_imm = '0;
    logic          in_ready, mem_we, err, done, full;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [2:0]    err_code;
    logic [7:0]    err_count;
    logic [AW:0]   count;

    logic          s_start = 1'b0, s_finish = 1'b0, s_valid = 1'b0;
    logic          s_ready, s_we, s_err, s_done, s_full;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata;
    logic [2:0]    s_err_code;
    logic [7:0]    s_err_count;
    logic [AW:0]   s_count;

    inst_encoder #(.ADDR_W(AW), .DEPTH(1024)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_alt(in_alt),
        .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .err(err), .err_code(err_code), .err_count(err_count), .count(count),
        .done(done), .full(full)
    );

    inst_encoder #(.ADDR_W(AW), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(s_start), .finish(s_finish), .base_addr(base_addr),
        .in_valid(s_valid), .in_ready(s_ready), .in_class(in_class), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_alt(in_alt),
        .in_imm(in_imm), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
        .err(s_err), .err_code(s_err_code), .err_count(s_err_count), .count(s_count),
        .done(s_done), .full(s_full)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            s_writes = 0;
    logic [AW-1:0] s_last_addr = '0;
    logic [AW-1:0] sb_addr = '0;
    wr_t           got_q[$];
    exp_t          exp_q[$];
    logic [2:0]    got_err_q[$];
    logic [2:0]    exp_err_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record everything the DUTs emit, away from the active edge.
    always @(negedge clk) begin
        wr_t w;
        if (mem_we === 1'b1) begin
            w.cyc = cyc; w.addr = mem_addr; w.data = mem_wdata;
            got_q.push_back(w);
        end
        if (err === 1'b1) got_err_q.push_back(err_code);
        if (s_we === 1'b1) begin
            s_writes    = s_writes + 1;
            s_last_addr = s_addr;
        end
    end

    task automatic send(input logic [3:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                        input logic [31:0] imm);
        int budget = 0;
        @(negedge clk);
        in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_alt = alt; in_imm = imm; in_valid = 1'b1;
        while (in_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
    endtask

    task automatic push_ok(input logic [3:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                           input logic [31:0] imm, input logic [31:0] w);
        exp_t e;
        e.addr = sb_addr; e.data = w;
        exp_q.push_back(e);
        sb_addr = sb_addr + 1'b1;
        send(c, rd, rs1, rs2, f3, alt, imm);
    endtask

    task automatic push_bad(input logic [3:0] c, input logic [2:0] f3, input logic [31:0] imm,
                            input logic [2:0] code);
        exp_err_q.push_back(code);
        send(c, 5'd1, 5'd2, 5'd3, f3, 1'b0, imm);
    endtask

    task automatic idle_cycles(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic start_session(input logic [AW-1:0] base);
        @(negedge clk);
        base_addr = base; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sb_addr = base;
        got_q.delete(); exp_q.delete(); got_err_q.delete(); exp_err_q.delete();
    endtask

    task automatic end_session();
        @(negedge clk); finish = 1'b1;
        @(negedge clk); finish = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, err, err_code, err_count, count, done, full} !== '0) begin
            n_bad++;
            $display("FAIL reset_values: rdy=%b we=%b addr=%h data=%h err=%b code=%0d ecnt=%0d cnt=%0d done=%b full=%b required all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, err, err_code, err_count, count, done, full);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({in_ready, mem_we, done, full, count} !== '0) begin
            n_bad++;
            $display("FAIL idle_after_reset: rdy=%b we=%b done=%b full=%b cnt=%0d required all 0",
                     in_ready, mem_we, done, full, count);
        end
    endtask

    task automatic test_back_to_back();
        start_session(10'h010);
        push_ok(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0,          32'h002081B3);
        push_ok(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFF,  32'hFFF00093);
        push_ok(4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8,          32'h0020A423);
        idle_cycles(2);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL b2b_writes: got %0d writes required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data ||
                got_q[i].cyc !== got_q[0].cyc + i) begin
                n_bad++;
                $display("FAIL b2b_word%0d: got %h@%h cyc+%0d required %h@%h cyc+%0d", i,
                         got_q[i].data, got_q[i].addr, got_q[i].cyc - got_q[0].cyc,
                         exp_q[i].data, exp_q[i].addr, i);
            end
        end
        n_cmp++;
        if (count !== 11'd3) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d required 3", count);
        end
    endtask

    task automatic test_formats();
        got_q.delete(); exp_q.delete();
        push_ok(4'd4, 5'd0,  5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFC, 32'hFE000EE3);
        push_ok(4'd1, 5'd5,  5'd5, 5'd0, 3'd5, 1'b1, 32'd3,         32'h4032D293);
        push_ok(4'd7, 5'd10, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000,  32'h12345537);
        push_ok(4'd5, 5'd1,  5'd0, 5'd0, 3'd0, 1'b0, 32'd8,         32'h008000EF);
        push_ok(4'd6, 5'd0,  5'd1, 5'd0, 3'd3, 1'b0, 32'd0,         32'h00008067);
        push_ok(4'd2, 5'd5,  5'd2, 5'd0, 3'd2, 1'b0, 32'd4,         32'h00412283);
        push_ok(4'd8, 5'd7,  5'd0, 5'd0, 3'd0, 1'b0, 32'hABCDE000,  32'hABCDE397);
        push_ok(4'd9, 5'd0,  5'd0, 5'd0, 3'd0, 1'b0, 32'd0,         32'h00000073);
        push_ok(4'd0, 5'd3,  5'd1, 5'd2, 3'd0, 1'b1, 32'd0,         32'h402081B3);
        push_ok(4'd5, 5'd0,  5'd0, 5'd0, 3'd0, 1'b0, 32'hFFF0_0000, 32'h8000006F);
        push_ok(4'd5, 5'd0,  5'd0, 5'd0, 3'd0, 1'b0, 32'd2,         32'h0020006F);
        push_ok(4'd4, 5'd0,  5'd0, 5'd0, 3'd1, 1'b0, 32'd4094,      32'h7E001FE3);
        push_ok(4'd1, 5'd1,  5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_F800, 32'h80000093);
        push_ok(4'd1, 5'd1,  5'd1, 5'd0, 3'd1, 1'b1, 32'd31,        32'h01F09093);
        push_ok(4'd3, 5'd0,  5'd2, 5'd3, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'hFE310FA3);
        idle_cycles(2);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL fmt_writes: got %0d writes required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data) begin
                n_bad++;
                $display("FAIL fmt_word%0d: got %h@%h required %h@%h", i,
                         got_q[i].data, got_q[i].addr, exp_q[i].data, exp_q[i].addr);
            end
        end
        n_cmp++;
        if (count !== 11'd18 || err_count !== 8'd0) begin
            n_bad++;
            $display("FAIL fmt_count: got cnt=%0d ecnt=%0d required 18/0", count, err_count);
        end
    endtask

    task automatic test_errors();
        end_session();
        start_session(10'h100);
        push_bad(4'd1,  3'd0, 32'd2048, 3'd2);
        push_bad(4'd4,  3'd0, 32'd3,    3'd3);
        push_bad(4'd12, 3'd0, 32'd0,    3'd1);
        idle_cycles(1);
        n_cmp++;
        if (err_count !== 8'd3 || count !== 11'd0 || got_q.size() != 0) begin
            n_bad++;
            $display("FAIL err_first3: got ecnt=%0d cnt=%0d writes=%0d required 3/0/0",
                     err_count, count, got_q.size());
        end
        push_bad(4'd4, 3'd2, 32'd4,          3'd4);
        push_bad(4'd4, 3'd3, 32'd3,          3'd4);
        push_bad(4'd1, 3'd5, 32'd32,         3'd2);
        push_bad(4'd1, 3'd1, 32'hFFFF_FFFF,  3'd2);
        push_bad(4'd7, 3'd0, 32'h12345001,   3'd2);
        push_bad(4'd5, 3'd0, 32'h0010_0000,  3'd2);
        push_bad(4'd5, 3'd0, 32'd1,          3'd3);
        push_bad(4'd4, 3'd0, 32'd4096,       3'd2);
        push_bad(4'd4, 3'd0, 32'd4095,       3'd2);
        push_bad(4'd3, 3'd0, 32'hFFFF_F7FF,  3'd2);
        push_ok(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 32'h002081B3);
        idle_cycles(2);
        n_cmp++;
        if (got_err_q.size() != exp_err_q.size()) begin
            n_bad++;
            $display("FAIL err_pulses: got %0d required %0d", got_err_q.size(), exp_err_q.size());
        end
        for (int i = 0; i < exp_err_q.size() && i < got_err_q.size(); i++) begin
            n_cmp++;
            if (got_err_q[i] !== exp_err_q[i]) begin
                n_bad++;
                $display("FAIL err_code%0d: got %0d required %0d", i, got_err_q[i], exp_err_q[i]);
            end
        end
        n_cmp++;
        if (got_q.size() != 1 || (got_q.size() == 1 && (got_q[0].addr !== 10'h100 || got_q[0].data !== 32'h002081B3))) begin
            n_bad++;
            $display("FAIL err_then_write: got %0d writes required one 002081b3@100", got_q.size());
        end
        n_cmp++;
        if (err_count !== 8'd13 || err !== 1'b0 || count !== 11'd1) begin
            n_bad++;
            $display("FAIL err_totals: got ecnt=%0d err=%b cnt=%0d required 13/0/1", err_count, err, count);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 260; i++) send(4'd15, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
        idle_cycles(1);
        n_cmp++;
        if (err_count !== 8'd255) begin
            n_bad++;
            $display("FAIL err_saturate: got %0d required 255", err_count);
        end
    endtask

    task automatic test_finish_pending();
        end_session();
        start_session(10'h020);
        exp_q.push_back('{10'h020, 32'h002081B3});
        @(negedge clk);
        in_class = 4'd0; in_rd = 5'd3; in_rs1 = 5'd1; in_rs2 = 5'd2;
        in_funct3 = 3'd0; in_alt = 1'b0; in_imm = 32'd0;
        in_valid = 1'b1; finish = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; finish = 1'b0;
        n_cmp++;
        if (mem_we !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL finish_drain: got we=%b rdy=%b done=%b required 1/0/0", mem_we, in_ready, done);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || mem_we !== 1'b0 || count !== 11'd1) begin
            n_bad++;
            $display("FAIL finish_done: got done=%b we=%b cnt=%0d required 1/0/1", done, mem_we, count);
        end
        n_cmp++;
        if (got_q.size() != 1 || (got_q.size() == 1 && (got_q[0].addr !== exp_q[0].addr || got_q[0].data !== exp_q[0].data))) begin
            n_bad++;
            $display("FAIL finish_write: got %0d writes required one %h@%h", got_q.size(), exp_q[0].data, exp_q[0].addr);
        end
    endtask

    task automatic test_start_finish();
        start_session(10'h000);
        push_ok(4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 32'h00000073);
        idle_cycles(0);
        @(negedge clk); base_addr = 10'h200; start = 1'b1;
        @(negedge clk); start = 1'b0;
        push_ok(4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 32'h00000073);
        idle_cycles(1);
        n_cmp++;
        if (got_q.size() != 2 || (got_q.size() == 2 && got_q[1].addr !== 10'h001) || count !== 11'd2) begin
            n_bad++;
            $display("FAIL start_in_run: got writes=%0d cnt=%0d required 2 writes, 2nd @001, cnt 2", got_q.size(), count);
        end
        @(negedge clk); start = 1'b1; finish = 1'b1;
        @(negedge clk); start = 1'b0; finish = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL start_finish_together: got done=%b rdy=%b required 1/0", done, in_ready);
        end
    endtask

    task automatic test_wrap();
        start_session(10'h3FF);
        push_ok(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00001000, 32'h000010B7);
        push_ok(4'd7, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00002000, 32'h00002137);
        idle_cycles(2);
        n_cmp++;
        if (got_q.size() != 2) begin
            n_bad++;
            $display("FAIL wrap_writes: got %0d required 2", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data) begin
                n_bad++;
                $display("FAIL wrap_word%0d: got %h@%h required %h@%h", i,
                         got_q[i].data, got_q[i].addr, exp_q[i].data, exp_q[i].addr);
            end
        end
    endtask

    task automatic test_reset_mid();
        end_session();
        start_session(10'h050);
        send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
        send(4'd0, 5'd4, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
        #2;
        n_cmp++;
        if (mem_we !== 1'b1 || count !== 11'd1) begin
            n_bad++;
            $display("FAIL pre_reset: got we=%b cnt=%0d required 1/1", mem_we, count);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({mem_we, count, mem_addr, mem_wdata, in_ready, done} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got we=%b cnt=%0d addr=%h data=%h rdy=%b done=%b required all 0",
                     mem_we, count, mem_addr, mem_wdata, in_ready, done);
        end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({mem_we, count, in_ready, done} !== '0) begin
            n_bad++;
            $display("FAIL reset_idle: got we=%b cnt=%0d rdy=%b done=%b required all 0", mem_we, count, in_ready, done);
        end
    endtask

    task automatic test_depth4();
        int accepts = 0;
        int ready_after = 0;
        s_writes = 0;
        @(negedge clk); base_addr = 10'h000; s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        in_class = 4'd0; in_rd = 5'd1; in_rs1 = 5'd1; in_rs2 = 5'd1;
        in_funct3 = 3'd0; in_alt = 1'b0; in_imm = 32'd0;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (s_ready === 1'b1 && accepts >= 4) ready_after++;
            if (s_ready === 1'b1) accepts++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        n_cmp++;
        if (accepts != 4 || s_writes != 4 || ready_after != 0) begin
            n_bad++;
            $display("FAIL depth4_accepts: got acc=%0d writes=%0d ready_late=%0d required 4/4/0",
                     accepts, s_writes, ready_after);
        end
        n_cmp++;
        if (s_full !== 1'b1 || s_done !== 1'b1 || s_count !== 11'd4 || s_ready !== 1'b0 || s_last_addr !== 10'h003) begin
            n_bad++;
            $display("FAIL depth4_state: got full=%b done=%b cnt=%0d rdy=%b last=%h required 1/1/4/0/003",
                     s_full, s_done, s_count, s_ready, s_last_addr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_formats();
        test_errors();
        test_saturate();
        test_finish_pending();
        test_start_finish();
        test_wrap();
        test_reset_mid();
        test_depth4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RV32I instruction encoder and program loader: accepts decoded instruction fields over a valid/ready handshake, packs them into 32-bit instruction words, and writes them sequentially into instruction memory starting at a programmable base. It is the producer side of the instruction decoder's format: every word it writes decodes back to the same fields. It sits between the test/boot host port and the instruction memory write port.

## Interface
- ADDR_W, 10, width of word address to instruction memory
- DEPTH, 1024, maximum words written per session (≤ 2^ADDR_W)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin session (honoured in IDLE/DONE only)
- finish  in  1  end session (honoured in RUN only)
- base_addr  in  ADDR_W  word address of first write, sampled on start
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept bundle
- in_class  in  4  0 R, 1 I-arith, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3  funct3
- in_alt  in  1  inst[30] select (SUB/SRA/SRAI)
- in_imm  in  32  signed immediate (U: full 32-bit value)
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- err  out  1  one-cycle pulse: bundle rejected
- err_code  out  3  1 bad class, 2 imm range, 3 misaligned, 4 bad funct3
- err_count  out  8  saturating rejected-bundle count
- count  out  ADDR_W+1  words written this session
- done  out  1  session ended
- full  out  1  DEPTH words written

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset → IDLE.
- IDLE/DONE + start → RUN; count, full, err_count cleared; base_addr latched.
- RUN + finish → DRAIN if a write is pending, else DONE. DRAIN → DONE once pending write retires.
- RUN: count reaching DEPTH → DONE, full=1.
- in_ready = (state==RUN) && (count + pending < DEPTH); depends on registered state only.
- Opcodes: R 0110011, I-arith 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, SYSTEM 1110011.
- Packing: standard RV32I R/I/S/B/U/J formats. R: inst[31:25]={0,alt,00000}. I-arith funct3 1/5: inst[31:25]={0,alt&(f3==5),00000}, inst[24:20]=imm[4:0]. JALR forces funct3=0.
- Checks, first match wins: class ≥10 → 1; BRANCH funct3 2/3 → 4; I/S/JALR/LOAD/SYSTEM imm outside −2048..2047 → 2; shift imm outside 0..31 → 2; B imm outside −4096..4094 or J outside −2^20..2^20−2 → 2; B/J imm[0]=1 → 3; U imm[11:0]≠0 → 2.
- Rejected bundle: no write, count unchanged, err pulse, err_count += 1 saturating at 255.
- mem_addr = base_addr + count, modulo 2^ADDR_W (wraps silently).

## Timing
- Transfer on rising edge with in_valid && in_ready. One-cycle latency: mem_we=1 for exactly the following cycle with mem_wdata/mem_addr; count increments at the end of that cycle.
- Back-to-back transfers sustain one write per cycle.
- err/err_code asserted in the cycle after the rejected transfer (same slot as mem_we would be).
- Transfer in the same cycle as finish is accepted and written; in_ready low from the next cycle.
- start and finish together in RUN: finish wins. start outside IDLE/DONE ignored.
- Reset mid-session: all outputs 0 immediately, pending write dropped, state IDLE.
- Reset values: in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, err 0, err_code 0, err_count 0, count 0, done 0, full 0.

## Test plan
- start base=0x010; send R add rd3 rs1 1 rs2 2, I-arith rd1 rs1 0 imm −1, STORE rs1 1 rs2 2 f3 2 imm 8 back-to-back → writes 0x002081B3@0x010, 0xFFF00093@0x011, 0x0020A423@0x012 on three consecutive cycles; count=3.
- BRANCH f3 0 rs1 0 rs2 0 imm −4 → 0xFE000EE3; I-arith f3 5 alt 1 rd5 rs1 5 imm 3 → 0x4032D293; LUI rd10 imm 0x12345000 → 0x12345537.
- I-arith imm 2048, BRANCH imm 3, class 12 → err codes 2, 3, 1; no mem_we; err_count=3; count unchanged.
- DEPTH=4 build: stream 6 bundles with in_valid held → exactly 4 writes, in_ready low after 4th accept, full=1, done=1.
- base=2^ADDR_W−1, two writes → addresses all-ones then 0.
- Assert rst while mem_we pending → mem_we 0 that cycle, count 0, state IDLE; finish with write pending → done one cycle after the write.
